// File: rtl/fifo_rr_drain.sv
// Round-robin burst scheduler draining NUM_SRC first-word-fall-through FIFOs
// into one registered valid/ready stream tagged with the source index.
module fifo_rr_drain #(
  parameter  int DWIDTH  = 32,
  parameter  int NUM_SRC = 4,
  parameter  int BURST   = 8,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC-1:0]        src_empty,
  input  logic [NUM_SRC*DWIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_rd_en,
  output logic [DWIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [SRC_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]  out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] eligible;
  logic               slot_free;
  logic               pop;
  logic               found;
  logic [SRC_W-1:0]   scan_idx;
  logic               end_burst;
  logic [DWIDTH-1:0]  src_word [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*DWIDTH +: DWIDTH];
  end

  // Rotating priority scan starting at ptr; the lowest-priority slot is the one just served.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        scan_idx = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    eligible    = ~src_empty & src_mask;
    slot_free   = !out_valid_q || out_ready;
    pop         = (state_q == GRANT) && eligible[gnt_q] && en && slot_free;
    src_rd_en   = '0;
    if (pop) src_rd_en[gnt_q] = 1'b1;

    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    end_burst   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && found) begin
          gnt_d   = scan_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (pop) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BURST - 1)) end_burst = 1'b1;
        end else if (!en || !eligible[gnt_q]) begin
          end_burst = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // cnt is cleared on exit so it never holds BURST.
    if (end_burst) begin
      state_d = IDLE;
      cnt_d   = '0;
      ptr_d   = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + SRC_W'(1);
    end

    if (pop) begin
      out_data_d  = src_word[gnt_q];
      out_src_d   = gnt_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == GRANT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench for fifo_rr_drain: queue-backed FIFOs, a transaction-level
// scheduler model, directed scenarios and a randomized soak.
module tb_fifo_rr_drain;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int BR = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [NS-1:0]    src_mask;
  logic [NS-1:0]    src_empty;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_rd_en;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  fifo_rr_drain #(.DWIDTH(DW), .NUM_SRC(NS), .BURST(BR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .src_mask  (src_mask),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_rd_en (src_rd_en),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Source FIFOs and the stream of words the sink accepted.
  logic [DW-1:0] fq [NS][$];
  int            acc_src [$];
  logic [DW-1:0] acc_data [$];

  // Scheduler model: who holds the grant, how many words taken, and whose turn is next.
  bit            m_busy;
  int            m_gnt, m_ptr, m_taken;
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_os;
  bit            m_pop;

  function automatic bit elig(int i);
    return (fq[i].size() > 0) && src_mask[i];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_ptr = 0; m_taken = 0;
    m_ov = 0; m_od = '0; m_os = 0; m_pop = 0;
  endtask

  task automatic finish_burst();
    m_busy = 0;
    m_ptr  = (m_gnt + 1) % NS;
  endtask

  task automatic model_edge();
    bit was_busy;
    was_busy = m_busy;
    if (m_pop) begin
      m_od = fq[m_gnt].pop_front();
      m_os = m_gnt;
      m_ov = 1;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (!was_busy) begin
      if (en) begin
        for (int j = 0; j < NS; j++) begin
          if (elig((m_ptr + j) % NS)) begin
            m_gnt = (m_ptr + j) % NS; m_taken = 0; m_busy = 1;
            break;
          end
        end
      end
    end else if (m_pop) begin
      m_taken++;
      if (m_taken == BR) finish_burst();
    end else if (!en || !elig(m_gnt)) begin
      finish_burst();
    end
  endtask

  // One clock: drive at negedge, check #1 later, advance the model after posedge.
  task automatic cycle(input bit e, input logic [NS-1:0] m, input bit r);
    @(negedge clk);
    en = e; src_mask = m; out_ready = r;
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = (fq[i].size() == 0);
      src_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
    #1;
    m_pop = m_busy && en && elig(m_gnt) && (!m_ov || out_ready);
    check("src_rd_en", src_rd_en, m_pop ? (64'd1 << m_gnt) : 64'd0);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_src", out_src, m_os);
    end
    if (out_valid && out_ready) begin
      acc_src.push_back(int'(out_src));
      acc_data.push_back(out_data);
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic fill(input int i, input int n);
    for (int k = 0; k < n; k++) fq[i].push_back(DW'($urandom));
  endtask

  initial begin
    int            budget;
    logic [DW-1:0] w [3];
    logic [NS-1:0] rmask;

    rst_n = 1'b0; en = 1'b0; src_mask = '1; src_empty = '1; src_data = '0; out_ready = 1'b1;
    model_reset();
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_en", src_rd_en, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_src", out_src, 0);
    @(negedge clk); rst_n = 1'b1;

    // Source 2 alone with three words: three pops, then exit on empty.
    w[0] = 16'hA0A0; w[1] = 16'hB1B1; w[2] = 16'hC2C2;
    for (int k = 0; k < 3; k++) fq[2].push_back(w[k]);
    acc_src.delete(); acc_data.delete();
    repeat (8) cycle(1, 4'hF, 1);
    check("s1_count", acc_src.size(), 3);
    for (int k = 0; k < 3 && k < acc_src.size(); k++) begin
      check("s1_src", acc_src[k], 2);
      check("s1_data", acc_data[k], w[k]);
    end
    // ptr now points at 3, so 3 wins over 0.
    fill(0, 1); fill(3, 1);
    acc_src.delete(); acc_data.delete();
    repeat (8) cycle(1, 4'hF, 1);
    check("s1_next_count", acc_src.size(), 2);
    if (acc_src.size() == 2) begin
      check("s1_next_first", acc_src[0], 3);
      check("s1_next_second", acc_src[1], 0);
    end

    // All sources full: full bursts in rotation starting at source 1.
    for (int i = 0; i < NS; i++) fill(i, BR);
    acc_src.delete(); acc_data.delete();
    repeat (26) cycle(1, 4'hF, 1);
    check("s2_count", acc_src.size(), 4 * BR);
    for (int n = 0; n < 4 * BR && n < acc_src.size(); n++)
      check("s2_order", acc_src[n], (1 + n / BR) % NS);

    // Backpressure on source 1 after its first word.
    fill(1, 3);
    cycle(1, 4'hF, 1);
    cycle(1, 4'hF, 1);
    repeat (5) cycle(1, 4'hF, 0);
    repeat (6) cycle(1, 4'hF, 1);

    // Mask 1010, then drop source 3's mask while it holds the grant.
    for (int i = 0; i < NS; i++) fill(i, 2 * BR);
    repeat (12) cycle(1, 4'b1010, 1);
    budget = 0;
    while (!(m_busy && m_gnt == 3) && budget < 40) begin
      cycle(1, 4'b1010, 1); budget++;
    end
    check("s4_grant3_reached", budget < 40, 1);
    repeat (4) cycle(1, 4'b0010, 1);

    // Drop en mid-burst with three words taken.
    for (int i = 0; i < NS; i++) fill(i, 2 * BR);
    budget = 0;
    while (!(m_busy && m_taken == 3) && budget < 40) begin
      cycle(1, 4'hF, 1); budget++;
    end
    check("s5_cnt3_reached", budget < 40, 1);
    repeat (3) cycle(0, 4'hF, 1);
    repeat (6) cycle(1, 4'hF, 1);

    // Asynchronous reset in the middle of a burst with a word in the output register.
    for (int i = 0; i < NS; i++) fq[i].delete();
    fill(0, 4); fill(2, 4);
    repeat (4) cycle(1, 4'hF, 0);
    budget = 0;
    while (!m_busy && budget < 10) begin cycle(1, 4'hF, 1); budget++; end
    repeat (2) cycle(1, 4'hF, 1);
    check("s6_pre_valid", m_ov && m_busy, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_out_valid", out_valid, 0);
    check("s6_rst_rd_en", src_rd_en, 0);
    check("s6_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    acc_src.delete(); acc_data.delete();
    repeat (6) cycle(1, 4'hF, 1);
    check("s6_first_after_reset", (acc_src.size() > 0) ? acc_src[0] : -1, 0);

    // Randomized soak.
    rmask = '1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NS; i++)
        if (fq[i].size() < 6 && $urandom_range(0, 2) == 0) fill(i, 1);
      if ($urandom_range(0, 49) == 0) rmask = NS'($urandom);
      cycle($urandom_range(0, 9) != 0, rmask, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
